// File: rtl/jt51_noise_pkg.sv
// Shared definitions for the JT51 noise LFSR checker and its generator model.
// The step-detect and prediction helpers are also used by the generator bench.
package jt51_noise_pkg;

  localparam int          LFSR_W     = 17;
  localparam int          TAP_A      = 16;
  localparam int          TAP_B      = 13;
  localparam logic [16:0] NOISE_INIT = 17'd14220;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } chk_state_e;

  // A noise step is any cycle where the strobe differs from its previous value.
  function automatic logic noise_step(input logic base, input logic last_base);
    return base != last_base;
  endfunction

  // Next bit of the XNOR recurrence s[n+17] = ~(s[n] ^ s[n+3]).
  function automatic logic noise_pred(input logic [LFSR_W-1:0] hist);
    return ~(hist[TAP_A] ^ hist[TAP_B]);
  endfunction

endpackage

// File: rtl/jt51_noise_pred.sv
// History shift register, step detection and next-bit prediction for the
// noise checker. hist bit 0 holds the newest sample.
module jt51_noise_pred
  import jt51_noise_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              base_i,
  input  logic              din_i,
  output logic              step_o,
  output logic              match_o,
  output logic [LFSR_W-1:0] hist_o,
  output logic [LFSR_W-1:0] hist_next_o
);

  logic              last_base_q;
  logic [LFSR_W-1:0] hist_q;
  logic [LFSR_W-1:0] hist_d;

  assign step_o      = noise_step(base_i, last_base_q);
  // The prediction uses the history before the incoming sample is shifted in.
  assign match_o     = (din_i == noise_pred(hist_q));
  assign hist_next_o = {hist_q[LFSR_W-2:0], din_i};
  assign hist_d      = step_o ? hist_next_o : hist_q;
  assign hist_o      = hist_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_base_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      last_base_q <= base_i;
      hist_q      <= hist_d;
    end
  end

endmodule

// File: rtl/jt51_noise_chk.sv
// Receive-side checker for the JT51 noise bit stream: locks onto the 17-bit
// sequence, flags mispredicted bits and keeps a saturating error count.
module jt51_noise_chk
  import jt51_noise_pkg::*;
#(
  parameter int MISS_MAX = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base,
  input  logic              din,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [LFSR_W-1:0] hist
);

  localparam logic [4:0] FILL_FULL = 5'(LFSR_W);
  localparam logic [3:0] MISS_LIM  = 4'(MISS_MAX);

  logic              step;
  logic              match;
  logic [LFSR_W-1:0] hist_next;

  chk_state_e        state_q, state_d;
  logic [4:0]        fill_q, fill_d;
  logic [3:0]        miss_q, miss_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  jt51_noise_pred u_pred (
    .clk         (clk),
    .rst         (rst),
    .base_i      (base),
    .din_i       (din),
    .step_o      (step),
    .match_o     (match),
    .hist_o      (hist),
    .hist_next_o (hist_next)
  );

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (step) begin
      case (state_q)
        ST_HUNT: begin
          fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 5'd1;
          // An all-ones window is the XNOR lock-up value and cannot be trusted.
          if (fill_d == FILL_FULL && hist_next != '1) begin
            state_d = ST_LOCK;
            miss_d  = '0;
          end
        end
        ST_LOCK: begin
          if (match) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 4'd1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if (miss_d == MISS_LIM) begin
              state_d = ST_HUNT;
              fill_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      fill_q  <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked  = (state_q == ST_LOCK);
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_jt51_noise_chk.sv
// Self-checking bench for jt51_noise_chk: a fixed event table plus randomized
// streams scored against a queue-based behavioural model of the checker.
module tb_jt51_noise_chk;
  import jt51_noise_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        base = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err;
  logic [7:0]  err_cnt;
  logic [16:0] hist;

  always #5 clk = ~clk;

  jt51_noise_chk #(.MISS_MAX(3), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .base    (base),
    .din     (din),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .hist    (hist)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
  endtask

  // Generator: true noise sequence seeded from NOISE_INIT.
  bit          gen_s[$];
  logic [16:0] seed = NOISE_INIT;

  task automatic gen_next(output bit b);
    int k;
    k = gen_s.size();
    if (k < 17) b = seed[k];
    else        b = ~(gen_s[k-17] ^ gen_s[k-14]);
    gen_s.push_back(b);
  endtask

  // Checker model: list of received samples plus lock bookkeeping.
  bit m_rx[$];
  int m_hunt, m_miss, m_cnt;
  bit m_locked, m_err;

  task automatic model_reset();
    m_rx.delete();
    m_hunt = 0; m_miss = 0; m_cnt = 0;
    m_locked = 0; m_err = 0;
  endtask

  function automatic logic [16:0] model_hist();
    logic [16:0] h;
    int sz;
    sz = m_rx.size();
    h  = '0;
    for (int i = 0; i < 17; i++)
      if (sz - 1 - i >= 0) h[i] = m_rx[sz-1-i];
    return h;
  endfunction

  task automatic model_step(input bit d, input bit c);
    bit pred;
    int sz;
    sz    = m_rx.size();
    m_err = 0;
    pred  = (sz >= 17) ? ~(m_rx[sz-17] ^ m_rx[sz-14]) : 1'b0;
    m_rx.push_back(d);
    if (m_locked) begin
      if (d != pred) begin
        m_err = 1;
        m_miss++;
        if (m_cnt < 255) m_cnt++;
        if (m_miss == 3) begin
          m_locked = 0; m_hunt = 0; m_miss = 0;
        end
      end else begin
        m_miss = 0;
      end
    end else begin
      if (m_hunt < 17) m_hunt++;
      if (m_hunt == 17 && model_hist() != 17'h1ffff) begin
        m_locked = 1; m_miss = 0;
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'(m_locked));
    check({tag, "_err"}, 32'(err), 32'(m_err));
    check({tag, "_cnt"}, 32'(err_cnt), 32'(m_cnt));
    check({tag, "_hist"}, 32'(hist), 32'(model_hist()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_err = 0;
      check_state("idle");
    end
  endtask

  task automatic do_step(input bit d, input bit c, input int gap);
    base = ~base; din = d; clr = c;
    @(posedge clk); #1;
    clr = 1'b0;
    model_step(d, c);
    check_state("step");
    idle(gap);
  endtask

  typedef struct {
    int step;
    bit flip;
    bit clr;
    bit exp_locked;
    bit exp_err;
    int exp_cnt;
  } vec_t;

  vec_t tbl[14];
  bit   g, f, c;
  int   idx, guard;

  initial begin
    // Steps count from 1 after reset; base toggles every 4 clk.
    // A corrupted sample is re-read 14 and 17 steps later, hence the extra errors.
    tbl[0]  = '{16, 0, 0, 0, 0, 0};
    tbl[1]  = '{17, 0, 0, 1, 0, 0};
    tbl[2]  = '{40, 1, 0, 1, 1, 1};
    tbl[3]  = '{41, 0, 0, 1, 0, 1};
    tbl[4]  = '{54, 0, 0, 1, 1, 2};
    tbl[5]  = '{57, 0, 0, 1, 1, 3};
    tbl[6]  = '{60, 1, 0, 1, 1, 4};
    tbl[7]  = '{61, 1, 0, 1, 1, 5};
    tbl[8]  = '{62, 1, 0, 0, 1, 6};
    tbl[9]  = '{78, 0, 0, 0, 0, 6};
    tbl[10] = '{79, 0, 0, 1, 0, 6};
    tbl[11] = '{90, 0, 1, 1, 0, 0};
    tbl[12] = '{95, 1, 1, 1, 1, 0};
    tbl[13] = '{96, 0, 0, 1, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    check("rst_hist", 32'(hist), 32'd0);
    @(posedge clk); #1;

    // Event table over the generator stream.
    for (int s = 1; s <= 100; s++) begin
      idx = -1;
      for (int i = 0; i < 14; i++) if (tbl[i].step == s) idx = i;
      gen_next(g);
      f = (idx >= 0) ? tbl[idx].flip : 1'b0;
      c = (idx >= 0) ? tbl[idx].clr  : 1'b0;
      do_step(g ^ f, c, 0);
      if (idx >= 0) begin
        check($sformatf("tbl%0d_locked", s), 32'(locked), 32'(tbl[idx].exp_locked));
        check($sformatf("tbl%0d_err", s), 32'(err), 32'(tbl[idx].exp_err));
        check($sformatf("tbl%0d_cnt", s), 32'(err_cnt), 32'(tbl[idx].exp_cnt));
      end
      idle(3);
    end

    // Static base with din wiggling: nothing may move.
    for (int i = 0; i < 8; i++) begin
      din = ~din;
      @(posedge clk); #1;
      m_err = 0;
      check_state("static");
    end

    // Random gaps (including back-to-back steps), sparse faults and clears.
    for (int s = 0; s < 2000; s++) begin
      gen_next(g);
      f = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 99) == 0);
      do_step(g ^ f, c, $urandom_range(0, 3));
    end

    // Dense faults drive the counter into saturation.
    guard = 0;
    while (guard < 6000 && m_cnt < 255) begin
      gen_next(g);
      do_step(g ^ 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 1));
      guard++;
    end
    for (int s = 0; s < 40; s++) begin
      gen_next(g);
      do_step(g ^ 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    check("sat_cnt", 32'(err_cnt), 32'd255);

    // Regain lock on the clean stream, then hit it with an async reset.
    guard = 0;
    while (guard < 200 && !m_locked) begin
      gen_next(g);
      do_step(g, 1'b0, 1);
      guard++;
    end
    check("pre_rst_locked", 32'(locked), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_cnt", 32'(err_cnt), 32'd0);
    check("arst_hist", 32'(hist), 32'd0);
    base = 1'b0; din = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    gen_s.delete();
    for (int s = 1; s <= 17; s++) begin
      gen_next(g);
      do_step(g, 1'b0, 2);
      if (s == 16) check("relock16", 32'(locked), 32'd0);
      if (s == 17) check("relock17", 32'(locked), 32'd1);
    end

    // din stuck at 1 from reset: the all-ones window never locks.
    @(posedge clk); #2;
    rst = 1'b1;
    base = 1'b0; din = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 40; s++) do_step(1'b1, 1'b0, 1);
    check("ones_locked", 32'(locked), 32'd0);
    check("ones_hist", 32'(hist), 32'h1ffff);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
